// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding a shift register,
// one bit per enabled cycle, bit order chosen per word; back-to-back words stream gap-free.
module serializer_tx #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dir,
    input  logic                  par_valid,
    output logic                  par_ready,
    input  logic [DATA_WIDTH-1:0] par,
    input  logic                  ser_en,
    output logic                  ser,
    output logic                  ser_valid,
    output logic                  ser_last
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic                  hold_dir;
    logic                  hold_v;
    logic [DATA_WIDTH-1:0] sh;
    logic                  sh_dir;
    logic [CW-1:0]         cnt;
    logic                  busy;
    logic                  accept;
    logic                  load;

    assign par_ready = !rst && !hold_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hold_v) state_nxt = SHIFT;
            SHIFT:   if (ser_last && !hold_v) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SHIFT);
        ser_valid = busy && ser_en;
        ser_last  = ser_valid && (cnt == LAST_IDX);
        ser       = 1'b0;
        if (ser_valid) ser = sh_dir ? sh[DATA_WIDTH-1] : sh[0];
        accept    = par_valid && par_ready;
        // Reload on the last bit's edge is what removes the bubble between words.
        load      = hold_v && (!busy || ser_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_dat <= '0;
            hold_dir <= 1'b0;
            hold_v   <= 1'b0;
            sh       <= '0;
            sh_dir   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                hold_dat <= par;
                hold_dir <= dir;
                hold_v   <= 1'b1;
            end
            if (load) begin
                sh     <= hold_dat;
                sh_dir <= hold_dir;
                cnt    <= '0;
                hold_v <= 1'b0;
            end else if (ser_valid) begin
                sh  <= sh_dir ? (sh << 1) : (sh >> 1);
                cnt <= ser_last ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule
